// File: rtl/decode_pkg.sv
// Shared decode constants and the control bundle carried by the decode stage.
package decode_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned ALU_W  = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
    localparam logic [OP_W-1:0] FN_XOR  = 6'b100110;
    localparam logic [OP_W-1:0] FN_NOR  = 6'b100111;
    localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [OP_W-1:0] FN_SLLV = 6'b000100;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SLLV = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_NOR  = 4'b1111;

    typedef struct packed {
        logic             branch;
        logic             bi;
        logic             jump;
        logic             ext_op;
        logic             reg_dst;
        logic             alusrc;
        logic             memtoreg;
        logic             regwrite;
        logic             memwrite;
        logic [ALU_W-1:0] aluctrl;
        logic             illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded bundle of the decode stage.
interface decode_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst;
    logic [DATA_W-1:0] pc_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] immi;
    logic [15:0]       offset;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [25:0]       instr_index;
    logic [4:0]        wr_reg;
    logic              branch;
    logic              bi;
    logic              jump;
    logic              ext_op;
    logic              reg_dst;
    logic              alusrc;
    logic              memtoreg;
    logic              regwrite;
    logic              memwrite;
    logic [3:0]        aluctrl;
    logic              illegal;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, in_valid, inst, pc_in, out_ready,
        input  in_ready, out_valid, pc_out, immi, offset, rs, rt, rd, shamt,
               instr_index, wr_reg, branch, bi, jump, ext_op, reg_dst, alusrc,
               memtoreg, regwrite, memwrite, aluctrl, illegal, stall_cnt
    );

    modport slave (
        input  flush, in_valid, inst, pc_in, out_ready,
        output in_ready, out_valid, pc_out, immi, offset, rs, rt, rd, shamt,
               instr_index, wr_reg, branch, bi, jump, ext_op, reg_dst, alusrc,
               memtoreg, regwrite, memwrite, aluctrl, illegal, stall_cnt
    );
endinterface

// File: rtl/decode_logic.sv
// Combinational MIPS decode: opcode/funct/immediate -> control bundle, immediate, register-use flags.
module decode_logic
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [OP_W-1:0]   funct_i,
    input  logic [IMM_W-1:0]  imm_i,
    output ctrl_t             ctrl_c,
    output logic [DATA_W-1:0] immi_c,
    output logic              uses_rs_c,
    output logic              uses_rt_c
);

    logic              sext;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;

    always_comb begin
        ctrl_c    = '0;
        sext      = 1'b0;
        uses_rs_c = 1'b1;
        uses_rt_c = 1'b0;
        case (op_i)
            OP_ADDI, OP_ADDIU: begin
                ctrl_c.aluctrl = ALU_ADD; ctrl_c.alusrc = 1'b1; ctrl_c.regwrite = 1'b1; sext = 1'b1;
            end
            OP_ANDI: begin ctrl_c.aluctrl = ALU_AND; ctrl_c.alusrc = 1'b1; ctrl_c.regwrite = 1'b1; end
            OP_ORI:  begin ctrl_c.aluctrl = ALU_OR;  ctrl_c.alusrc = 1'b1; ctrl_c.regwrite = 1'b1; end
            OP_XORI: begin ctrl_c.aluctrl = ALU_XOR; ctrl_c.alusrc = 1'b1; ctrl_c.regwrite = 1'b1; end
            OP_SLTI: begin
                ctrl_c.aluctrl = ALU_SLT; ctrl_c.alusrc = 1'b1; ctrl_c.regwrite = 1'b1; sext = 1'b1;
            end
            OP_LW: begin
                ctrl_c.aluctrl = ALU_ADD; ctrl_c.alusrc = 1'b1; ctrl_c.regwrite = 1'b1;
                ctrl_c.memtoreg = 1'b1; sext = 1'b1;
            end
            OP_SW: begin
                ctrl_c.aluctrl = ALU_ADD; ctrl_c.alusrc = 1'b1; ctrl_c.memwrite = 1'b1;
                sext = 1'b1; uses_rt_c = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_c.branch = 1'b1; ctrl_c.aluctrl = ALU_SUB; ctrl_c.bi = (op_i == OP_BEQ);
                sext = 1'b1; uses_rt_c = 1'b1;
            end
            OP_J: begin
                ctrl_c.jump = 1'b1; ctrl_c.aluctrl = ALU_ADD; uses_rs_c = 1'b0;
            end
            OP_RTYPE: begin
                uses_rt_c       = 1'b1;
                ctrl_c.reg_dst  = 1'b1;
                ctrl_c.regwrite = 1'b1;
                case (funct_i)
                    FN_ADD:  ctrl_c.aluctrl = ALU_ADD;
                    FN_SUB:  ctrl_c.aluctrl = ALU_SUB;
                    FN_AND:  ctrl_c.aluctrl = ALU_AND;
                    FN_OR:   ctrl_c.aluctrl = ALU_OR;
                    FN_XOR:  ctrl_c.aluctrl = ALU_XOR;
                    FN_NOR:  ctrl_c.aluctrl = ALU_NOR;
                    FN_SLT:  ctrl_c.aluctrl = ALU_SLT;
                    FN_SLLV: ctrl_c.aluctrl = ALU_SLLV;
                    default: begin
                        ctrl_c.reg_dst  = 1'b0;
                        ctrl_c.regwrite = 1'b0;
                        ctrl_c.aluctrl  = ALU_SUB;
                        ctrl_c.illegal  = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl_c.aluctrl = ALU_SUB;
                ctrl_c.illegal = 1'b1;
            end
        endcase
        ctrl_c.ext_op = sext & imm_i[IMM_W-1];
    end

    assign imm_sext = DATA_W'($signed(imm_i));
    assign imm_zext = DATA_W'(imm_i);
    assign immi_c   = ctrl_c.ext_op ? imm_sext : imm_zext;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: single-entry bundle register, valid/ready handshake,
// load-use interlock with saturating bubble counter, synchronous flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter bit          HAZARD_EN = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);

    ctrl_t             ctrl_c, ctrl_q;
    logic [DATA_W-1:0] immi_c, immi_q, pc_q;
    logic [25:0]       inst_q;
    logic [REG_W-1:0]  wr_reg_q, held_rt;
    logic              valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              uses_rs_c, uses_rt_c, hazard_c, in_ready_c, load_c, bubble_c;

    decode_logic #(.DATA_W(DATA_W)) u_decode_logic (
        .op_i      (bus.inst[31:26]),
        .funct_i   (bus.inst[5:0]),
        .imm_i     (bus.inst[15:0]),
        .ctrl_c    (ctrl_c),
        .immi_c    (immi_c),
        .uses_rs_c (uses_rs_c),
        .uses_rt_c (uses_rt_c)
    );

    // Held lw targets a register the incoming instruction reads; constant-folds away when disabled.
    assign held_rt  = inst_q[20:16];
    assign hazard_c = HAZARD_EN & valid_q & ctrl_q.memtoreg & (held_rt != '0) & bus.in_valid &
                      ((uses_rs_c & (bus.inst[25:21] == held_rt)) |
                       (uses_rt_c & (bus.inst[20:16] == held_rt)));

    assign in_ready_c = (~valid_q | bus.out_ready) & ~hazard_c & ~bus.flush;
    assign load_c     = bus.in_valid & in_ready_c;
    assign bubble_c   = hazard_c & bus.out_ready & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            immi_q   <= '0;
            pc_q     <= '0;
            inst_q   <= '0;
            wr_reg_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (load_c) begin
                valid_q  <= 1'b1;
                ctrl_q   <= ctrl_c;
                immi_q   <= immi_c;
                pc_q     <= bus.pc_in;
                inst_q   <= bus.inst[25:0];
                wr_reg_q <= ctrl_c.reg_dst ? bus.inst[15:11] : bus.inst[20:16];
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (bubble_c && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = valid_q;
    assign bus.pc_out      = pc_q;
    assign bus.immi        = immi_q;
    assign bus.offset      = inst_q[15:0];
    assign bus.rs          = inst_q[25:21];
    assign bus.rt          = inst_q[20:16];
    assign bus.rd          = inst_q[15:11];
    assign bus.shamt       = inst_q[10:6];
    assign bus.instr_index = inst_q;
    assign bus.wr_reg      = wr_reg_q;
    assign bus.branch      = ctrl_q.branch;
    assign bus.bi          = ctrl_q.bi;
    assign bus.jump        = ctrl_q.jump;
    assign bus.ext_op      = ctrl_q.ext_op;
    assign bus.reg_dst     = ctrl_q.reg_dst;
    assign bus.alusrc      = ctrl_q.alusrc;
    assign bus.memtoreg    = ctrl_q.memtoreg;
    assign bus.regwrite    = ctrl_q.regwrite;
    assign bus.memwrite    = ctrl_q.memwrite;
    assign bus.aluctrl     = ctrl_q.aluctrl;
    assign bus.illegal     = ctrl_q.illegal;
    assign bus.stall_cnt   = cnt_q;

endmodule
